hpu_ctrl_regs: RTL and testbench
================================

HPU_CTRL_REGS -- requirements
Module: hpu_ctrl_regs

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, named as below.
REQ-002 SHALL have parameter ADDR_W, default 12: AXI-Lite address width.
REQ-003 SHALL have parameter NUM_USER_REGS, default 4, range 1..32: count of generic 32-bit user registers.
REQ-004 SHALL have parameter MAT_WORDS, default 100, range 2..65535: matrix-load length in cycles.
REQ-005 SHALL have these ports, clock and reset first:
- clk  in  1  clock for the AXI-Lite side and all outputs
- rst  in  1  synchronous active-high reset
- S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY: AXI-Lite write channels; addresses are ADDR_W wide, data 32, strobe 4, resp 2.
- S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: AXI-Lite read channels, same widths.
- done  in  1  single-cycle pulse from the datapath when a run completes
- matw  out  1  matrix-write enable
- run  out  1  run enable
- last  out  1  last-batch flag
- user_regs  out  32*NUM_USER_REGS  user registers, register i in bits [32i+31:32i]
- irq  out  1  done interrupt; exists only with CTRL_IRQ_EN

Function
REQ-006 SHALL decode the word address as {ADDR[ADDR_W-1:2],00}.
- 0x000 CTRL, RW: [0] matw, [1] run, [2] last
- 0x004 STATUS, RO: [2:0] {last,run,matw}, [3] done_sticky, [31:16] mat_cnt
- 0x008 IRQ_EN, RW: [0]; with CTRL_IRQ_EN only
- 0x010+4i USER[i], RW
REQ-007 SHALL run the write FSM IDLE->(AW|W|AWW)->IDLE. AWREADY=IDLE|W; WREADY=IDLE|AW; BVALID=AWW. AWW returns to IDLE on BREADY.
REQ-008 SHALL run the read FSM IDLE->AR1->AR2->IDLE. ARREADY=IDLE; RVALID=AR2. RDATA is registered in AR1 and held stable until RREADY.
REQ-009 SHALL, in IDLE with AWVALID and ARVALID both asserted, accept the write and leave ARREADY low that cycle.
REQ-010 SHALL apply the write in the cycle the FSM enters AWW, per byte lane, only where WSTRB[n]=1.
REQ-011 SHALL answer an unmapped address or a write to STATUS with SLVERR (2'b10); the write is ignored and the read returns 0. Mapped accesses answer OKAY (2'b00).
REQ-012 SHALL count mat_cnt up by 1 each cycle while matw=1 and hold it at 0 while matw=0.
REQ-013 SHALL clear matw in the cycle after mat_cnt==MAT_WORDS-1, so matw is high for exactly MAT_WORDS cycles.
REQ-014 SHALL let a CTRL write that lands in the same cycle as the auto-clear win; the counter then restarts from 0.
REQ-015 SHALL set done_sticky on a done pulse and clear it on any CTRL write with run=0. If both happen in the same cycle, set wins.

Reset
REQ-016 SHALL, with rst=1 at a clk edge, reset:
- both FSMs to IDLE
- matw, run, last, done_sticky, mat_cnt, IRQ_EN, user_regs and irq to 0
- BVALID, RVALID, BRESP, RRESP and RDATA to 0
REQ-017 SHALL abandon any outstanding transaction when reset is asserted mid-transaction, without issuing a response.

Configuration
REQ-018 SHALL compile in, when the macro CTRL_IRQ_EN is defined:
- the IRQ_EN register
- the irq port, driven as registered irq = done_sticky & IRQ_EN[0], with one cycle of latency
REQ-019 SHALL, when CTRL_IRQ_EN is undefined, omit the irq port and answer 0x008 as unmapped (SLVERR, reads 0).

Verification
REQ-020 SHALL cover: reset, then read 0x004 -> RDATA=0x00000000, RRESP=00.
REQ-021 SHALL cover: write 0x000=0x1 -> matw high for exactly 100 cycles, STATUS[31:16] reads 0..99, matw then returns to 0 by itself.
REQ-022 SHALL cover: write 0x014=0xAABBCCDD with WSTRB=0101, starting from 0 -> user_regs[63:32]=0x00BB00DD.
REQ-023 SHALL cover: write 0x0FC -> BRESP=10, no state change; read 0x0FC -> RDATA=0, RRESP=10.
REQ-024 SHALL cover: AWVALID, WVALID and ARVALID asserted together -> write completes first, read completes afterwards.
REQ-025 SHALL cover, with CTRL_IRQ_EN: IRQ_EN=1, then done pulse -> irq=1 one cycle later; write 0x000=0x0 -> irq=0.

Source files
------------

// File: rtl/hpu_ctrl_regs_if.sv
// hpu_ctrl_regs_if -- AXI-Lite slave bundle for the HPU control register block.
//   Parameter ADDR_W : address width of the AW/AR channels.
//   master : drives addresses, write data/strobes and the B/R ready signals.
//   slave  : drives the ready signals on AW/W/AR and the B/R responses.
interface hpu_ctrl_regs_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hpu_ctrl_regs.sv
// hpu_ctrl_regs -- AXI-Lite control/status registers for the HPU datapath.
//   clk       : single clock for bus and outputs
//   rst       : synchronous active-high reset
//   s_axi     : AXI-Lite slave (hpu_ctrl_regs_if.slave)
//   done      : one-cycle completion pulse from the datapath
//   matw      : matrix-write enable, self-clears after MAT_WORDS cycles
//   run, last : run enable and last-batch flag
//   user_regs : NUM_USER_REGS generic registers, reg i at [32i+31:32i]
//   irq       : registered done_sticky & IRQ_EN[0] (only with CTRL_IRQ_EN)
// Map: 0x000 CTRL, 0x004 STATUS (RO), 0x008 IRQ_EN (CTRL_IRQ_EN), 0x010+4i USER[i].
// Optional feature macro: CTRL_IRQ_EN (IRQ_EN register and irq port).
//
// Write FSM: W_IDLE | idle ; W_AW | address held, waiting data ; W_W | data held,
//            waiting address ; W_AWW | write applied, BVALID high
// Read FSM:  R_IDLE | idle ; R_AR1 | RDATA/RRESP being registered ; R_AR2 | RVALID high
module hpu_ctrl_regs #(
  parameter int ADDR_W        = 12,
  parameter int NUM_USER_REGS = 4,
  parameter int MAT_WORDS     = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  hpu_ctrl_regs_if.slave             s_axi,
  input  logic                       done,
  output logic                       matw,
  output logic                       run,
  output logic                       last,
  output logic [32*NUM_USER_REGS-1:0] user_regs
`ifdef CTRL_IRQ_EN
  ,
  output logic                       irq
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_AWW} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_AR1, R_AR2} rstate_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_CTRL, SEL_STATUS, SEL_IRQEN, SEL_USER} sel_t;
  typedef struct packed {
    sel_t       sel;
    logic [4:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] wa;
    dec_t d;
    wa    = {a[ADDR_W-1:2], 2'b00};
    d.sel = SEL_NONE;
    d.idx = '0;
    if (wa == ADDR_W'(0)) d.sel = SEL_CTRL;
    if (wa == ADDR_W'(4)) d.sel = SEL_STATUS;
`ifdef CTRL_IRQ_EN
    if (wa == ADDR_W'(8)) d.sel = SEL_IRQEN;
`endif
    for (int i = 0; i < NUM_USER_REGS; i++) begin
      if (wa == ADDR_W'(16 + 4*i)) begin
        d.sel = SEL_USER;
        d.idx = 5'(i);
      end
    end
    return d;
  endfunction

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [31:0]       w_data_q, rdata_q, rd_val;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic              rd_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_fire, ctrl_wr;
  dec_t              wdec, rdec;
  logic [15:0]       mat_cnt;
  logic              done_sticky;
  logic [31:0]       user_q [NUM_USER_REGS];
`ifdef CTRL_IRQ_EN
  logic              irq_en;
`endif

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wnext;
  end

  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) wnext = W_AWW;
        else if (s_axi.awvalid)            wnext = W_AW;
        else if (s_axi.wvalid)             wnext = W_W;
      end
      W_AW:    if (s_axi.wvalid)  wnext = W_AWW;
      W_W:     if (s_axi.awvalid) wnext = W_AWW;
      W_AWW:   if (s_axi.bready)  wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = (wstate == W_IDLE) || (wstate == W_W);
    s_axi.wready  = (wstate == W_IDLE) || (wstate == W_AW);
    s_axi.bvalid  = (wstate == W_AWW);
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (s_axi.arvalid && s_axi.arready) rnext = R_AR1;
      R_AR1:   rnext = R_AR2;
      R_AR2:   if (s_axi.rready) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  // A write address offered while the write side is idle takes priority,
  // so the read waits and always observes the completed write.
  always_comb begin
    s_axi.arready = (rstate == R_IDLE) && !((wstate == W_IDLE) && s_axi.awvalid);
    s_axi.rvalid  = (rstate == R_AR2);
  end

  // ---------------- datapath ----------------
  // A half-accepted write takes the held half from the capture registers
  // and the other half straight from the bus.
  assign wr_addr = (wstate == W_AW) ? aw_addr_q : s_axi.awaddr;
  assign wr_data = (wstate == W_W)  ? w_data_q  : s_axi.wdata;
  assign wr_strb = (wstate == W_W)  ? w_strb_q  : s_axi.wstrb;
  assign wr_fire = (wstate != W_AWW) && (wnext == W_AWW);
  assign wdec    = decode(wr_addr);
  assign rdec    = decode(ar_addr_q);
  assign ctrl_wr = wr_fire && (wdec.sel == SEL_CTRL) && wr_strb[0];

  assign s_axi.bresp = bresp_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rdec.sel)
      SEL_CTRL:   rd_val = {29'd0, last, run, matw};
      SEL_STATUS: rd_val = {mat_cnt, 12'd0, done_sticky, last, run, matw};
`ifdef CTRL_IRQ_EN
      SEL_IRQEN:  rd_val = {31'd0, irq_en};
`endif
      SEL_USER: begin
        for (int i = 0; i < NUM_USER_REGS; i++)
          if (rdec.idx == 5'(i)) rd_val = user_q[i];
      end
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      matw        <= 1'b0;
      run         <= 1'b0;
      last        <= 1'b0;
      mat_cnt     <= '0;
      done_sticky <= 1'b0;
      for (int i = 0; i < NUM_USER_REGS; i++) user_q[i] <= '0;
`ifdef CTRL_IRQ_EN
      irq_en      <= 1'b0;
      irq         <= 1'b0;
`endif
    end else begin
      if (s_axi.awvalid && s_axi.awready) aw_addr_q <= s_axi.awaddr;
      if (s_axi.wvalid && s_axi.wready) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (s_axi.arvalid && s_axi.arready) ar_addr_q <= s_axi.araddr;

      if (wr_fire)
        bresp_q <= ((wdec.sel == SEL_NONE) || (wdec.sel == SEL_STATUS)) ? 2'b10 : 2'b00;

      if (rstate == R_AR1) begin
        rdata_q <= rd_err ? 32'd0 : rd_val;
        rresp_q <= rd_err ? 2'b10 : 2'b00;
      end

      // A CTRL write overrides the auto-clear and restarts the load count.
      if (ctrl_wr) begin
        matw    <= wr_data[0];
        run     <= wr_data[1];
        last    <= wr_data[2];
        mat_cnt <= '0;
      end else if (matw) begin
        if (mat_cnt == 16'(MAT_WORDS - 1)) begin
          matw    <= 1'b0;
          mat_cnt <= '0;
        end else begin
          mat_cnt <= mat_cnt + 16'd1;
        end
      end

      if (done)                         done_sticky <= 1'b1;
      else if (ctrl_wr && !wr_data[1])  done_sticky <= 1'b0;

      if (wr_fire && (wdec.sel == SEL_USER)) begin
        for (int i = 0; i < NUM_USER_REGS; i++)
          if (wdec.idx == 5'(i))
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) user_q[i][8*b +: 8] <= wr_data[8*b +: 8];
      end

`ifdef CTRL_IRQ_EN
      if (wr_fire && (wdec.sel == SEL_IRQEN) && wr_strb[0]) irq_en <= wr_data[0];
      irq <= done_sticky & irq_en;
`endif
    end
  end

  for (genvar g = 0; g < NUM_USER_REGS; g++) begin : g_user
    assign user_regs[32*g +: 32] = user_q[g];
  end

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
module tb_hpu_ctrl_regs;
  localparam int ADDR_W = 12;
  localparam int NUM    = 4;
  localparam int MW     = 100;
  localparam int NV     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic matw, run, last;
  logic [32*NUM-1:0] user_regs;
`ifdef CTRL_IRQ_EN
  logic irq;
`endif

  hpu_ctrl_regs_if #(.ADDR_W(ADDR_W)) axi ();

  hpu_ctrl_regs #(.ADDR_W(ADDR_W), .NUM_USER_REGS(NUM), .MAT_WORDS(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (axi),
    .done      (done),
    .matw      (matw),
    .run       (run),
    .last      (last),
    .user_regs (user_regs)
`ifdef CTRL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int matw_hi = 0;
  int w_edge = 0, ar_edge = 0, b_edge = 0, r_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (matw === 1'b1) matw_hi = matw_hi + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;
  logic [1:0] b_q [$];
  rexp_t      r_q [$];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          hold;
  } vec_t;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input string name);
    bit aw_ok = 0, w_ok = 0, got = 0, aw_hs, w_hs;
    logic [1:0] e;
    b_q.push_back(exp_resp);
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d;  axi.wstrb = s; axi.wvalid = 1'b1;
    for (int i = 0; i < 50 && !(aw_ok && w_ok); i++) begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_ok = 1; axi.awvalid = 1'b0; end
      if (w_hs)  begin w_ok = 1;  axi.wvalid = 1'b0; end
    end
    if (!(aw_ok && w_ok)) begin
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      void'(b_q.pop_front());
      timeout({name, " aw/w"});
      return;
    end
    w_edge = cyc;
    axi.bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.bvalid === 1'b1) begin
        e = b_q.pop_front();
        check({name, " bresp"}, 32'(axi.bresp), 32'(e));
        got = 1;
      end
      @(posedge clk); #1;
      if (got) break;
    end
    axi.bready = 1'b0;
    b_edge = cyc;
    if (!got) begin
      void'(b_q.pop_front());
      timeout({name, " b"});
    end
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                          input string name, input bit status_mode, input int hold);
    bit ok = 0, got = 0, seen = 0, hs;
    int waited = 0, dd;
    logic [31:0] first = '0;
    rexp_t e;
    if (!status_mode) r_q.push_back('{exp_d, exp_r});
    axi.araddr = a; axi.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = axi.arvalid && axi.arready;
      @(posedge clk); #1;
      if (hs) begin ok = 1; axi.arvalid = 1'b0; break; end
    end
    if (!ok) begin
      axi.arvalid = 1'b0;
      if (!status_mode) void'(r_q.pop_front());
      timeout({name, " ar"});
      return;
    end
    ar_edge = cyc;
    if (status_mode) begin
      // matw rose at the write edge; RDATA is captured one edge after AR acceptance.
      dd = ar_edge - w_edge;
      r_q.push_back('{(dd < MW) ? ((32'(dd) << 16) | 32'd1) : 32'd0, 2'b00});
    end
    axi.rready = (hold == 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (axi.rvalid === 1'b1) begin
        if (!seen) begin seen = 1; first = axi.rdata; end
        if (axi.rready) begin
          e = r_q.pop_front();
          check({name, " rdata"}, axi.rdata, e.data);
          check({name, " rresp"}, 32'(axi.rresp), 32'(e.resp));
          if (hold > 0) check({name, " rdata stable"}, axi.rdata, first);
          got = 1;
        end else begin
          waited++;
        end
      end
      @(posedge clk); #1;
      if (got) break;
      if (seen && waited >= hold) axi.rready = 1'b1;
    end
    axi.rready = 1'b0;
    r_edge = cyc;
    if (!got) begin
      void'(r_q.pop_front());
      timeout({name, " r"});
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, seen_b, seen_r;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    vecs[0]  = '{0, 12'h004, 32'h0,        4'h0, 32'h0,        2'b00, 0};
    vecs[1]  = '{1, 12'h014, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00, 0};
    vecs[2]  = '{0, 12'h014, 32'h0,        4'h0, 32'h00BB00DD, 2'b00, 3};
    vecs[3]  = '{1, 12'h0FC, 32'h12345678, 4'hF, 32'h0,        2'b10, 0};
    vecs[4]  = '{0, 12'h0FC, 32'h0,        4'h0, 32'h0,        2'b10, 0};
    vecs[5]  = '{1, 12'h004, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 0};
    vecs[6]  = '{0, 12'h004, 32'h0,        4'h0, 32'h0,        2'b00, 0};
    vecs[7]  = '{1, 12'h010, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 0};
    vecs[8]  = '{1, 12'h010, 32'h00000000, 4'h8, 32'h0,        2'b00, 0};
    vecs[9]  = '{0, 12'h010, 32'h0,        4'h0, 32'h00FFFFFF, 2'b00, 0};
    vecs[10] = '{1, 12'h01C, 32'h12345678, 4'hF, 32'h0,        2'b00, 0};
    vecs[11] = '{0, 12'h01F, 32'h0,        4'h0, 32'h12345678, 2'b00, 0};
    vecs[12] = '{0, 12'h020, 32'h0,        4'h0, 32'h0,        2'b10, 0};
    vecs[13] = '{1, 12'h000, 32'h00000006, 4'h1, 32'h0,        2'b00, 0};
    vecs[14] = '{0, 12'h004, 32'h0,        4'h0, 32'h00000006, 2'b00, 0};
`ifdef CTRL_IRQ_EN
    vecs[15] = '{0, 12'h008, 32'h0,        4'h0, 32'h0,        2'b00, 0};
`else
    vecs[15] = '{0, 12'h008, 32'h0,        4'h0, 32'h0,        2'b10, 0};
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst matw", 32'(matw), 0);
    check("rst run", 32'(run), 0);
    check("rst last", 32'(last), 0);
    check("rst user_regs", 32'(user_regs == '0), 1);
    check("rst bvalid", 32'(axi.bvalid), 0);
    check("rst rvalid", 32'(axi.rvalid), 0);
    check("rst rdata", axi.rdata, 0);
    check("rst resp", {28'd0, axi.bresp, axi.rresp}, 0);
`ifdef CTRL_IRQ_EN
    check("rst irq", 32'(irq), 0);
`endif
    @(posedge clk); #1;

    // register map vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, $sformatf("vec%0d", i));
      else
        axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("vec%0d", i), 0, vecs[i].hold);
    end
    check("user0 port", user_regs[31:0], 32'h00FFFFFF);
    check("user1 port", user_regs[63:32], 32'h00BB00DD);
    check("user2 port", user_regs[95:64], 32'h0);
    check("user3 port", user_regs[127:96], 32'h12345678);
    check("run/last/matw port", {29'd0, last, run, matw}, 32'h6);

    // simultaneous AW, W and AR: write first, read sees new data
    fork
      axi_write(12'h018, 32'hCAFEF00D, 4'hF, 2'b00, "simul wr");
      axi_read(12'h018, 32'hCAFEF00D, 2'b00, "simul rd", 0, 0);
    join
    check("simul ar after write", 32'(ar_edge > w_edge), 1);
    check("simul b before r", 32'(b_edge < r_edge), 1);

    // matrix load: matw high exactly MW cycles, STATUS tracks mat_cnt
    axi_write(12'h000, 32'h0, 4'h1, 2'b00, "ctrl clr");
    matw_hi = 0;
    axi_write(12'h000, 32'h1, 4'h1, 2'b00, "matw start");
    for (int i = 0; i < 40; i++) axi_read(12'h004, 32'h0, 2'b00, $sformatf("status%0d", i), 1, 0);
    for (int i = 0; i < 300 && matw === 1'b1; i++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk); #1;
    check("matw cycles", 32'(matw_hi), MW);
    check("matw self clear", 32'(matw), 0);

    // CTRL write landing on the auto-clear edge wins and restarts the count
    matw_hi = 0;
    axi_write(12'h000, 32'h1, 4'h1, 2'b00, "matw start2");
    base = w_edge;
    for (int i = 0; i < 200 && cyc < base + MW - 1; i++) begin @(posedge clk); #1; end
    axi_write(12'h000, 32'h1, 4'h1, 2'b00, "matw collide");
    for (int i = 0; i < 300 && matw === 1'b1; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk); #1;
    check("matw collide cycles", 32'(matw_hi), 2 * MW);

    // done_sticky
    pulse_done();
    axi_read(12'h004, 32'h8, 2'b00, "sticky set", 0, 0);
    axi_write(12'h000, 32'h2, 4'h1, 2'b00, "ctrl run");
    axi_read(12'h004, 32'hA, 2'b00, "sticky kept", 0, 0);
    axi_write(12'h000, 32'h0, 4'h1, 2'b00, "ctrl stop");
    axi_read(12'h004, 32'h0, 2'b00, "sticky clr", 0, 0);
    fork
      axi_write(12'h000, 32'h0, 4'h1, 2'b00, "ctrl vs done");
      pulse_done();
    join
    axi_read(12'h004, 32'h8, 2'b00, "sticky set wins", 0, 0);
    axi_write(12'h000, 32'h0, 4'h1, 2'b00, "ctrl stop2");

`ifdef CTRL_IRQ_EN
    axi_write(12'h008, 32'h1, 4'h1, 2'b00, "irq_en wr");
    axi_read(12'h008, 32'h1, 2'b00, "irq_en rd", 0, 0);
    pulse_done();
    @(negedge clk);
    check("irq latency", 32'(irq), 0);
    @(negedge clk);
    check("irq set", 32'(irq), 1);
    @(posedge clk); #1;
    axi_write(12'h000, 32'h0, 4'h1, 2'b00, "irq clr wr");
    check("irq clr", 32'(irq), 0);
`endif

    // reset in the middle of a write (address accepted, data pending)
    axi.awaddr = 12'h010; axi.awvalid = 1'b1;
    @(posedge clk); #1;
    axi.awvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_b = 0;
    repeat (5) begin @(negedge clk); if (axi.bvalid !== 1'b0) seen_b++; end
    check("rst mid write no bvalid", 32'(seen_b), 0);
    check("rst mid write user_regs", 32'(user_regs == '0), 1);
    @(posedge clk); #1;

    // reset in the middle of a read
    axi.araddr = 12'h004; axi.arvalid = 1'b1;
    @(posedge clk); #1;
    axi.arvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_r = 0;
    repeat (5) begin @(negedge clk); if (axi.rvalid !== 1'b0) seen_r++; end
    check("rst mid read no rvalid", 32'(seen_r), 0);
    @(posedge clk); #1;
    axi_read(12'h010, 32'h0, 2'b00, "post rst rd", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
